// File: rtl/incubator_power_scheduler.sv
// incubator_power_scheduler: shares one heater/cooler power stage between four
// incubator zones. Zones are granted round-robin, each grant holds for at least
// MIN_ON cycles, and every grant is followed by GUARD all-off dead-time cycles so
// the two actuators can never overlap or switch directly into each other.
// Optional feature macro: INCUBATOR_SCHED_PREEMPT_EN -- when defined, a grant that
// has run SLICE cycles is released as soon as any other zone is requesting.
module incubator_power_scheduler #(
  parameter int MIN_ON = 8,
  parameter int GUARD  = 2,
  parameter int SLICE  = 32
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [3:0] req,
  input  logic [3:0] mode,
  output logic [3:0] grant,
  output logic       Heater,
  output logic       Cooler,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ON    = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  localparam logic [7:0] MinOnLast = 8'(MIN_ON - 1);
  localparam logic [7:0] GuardLast = 8'(GUARD - 1);

  state_t     r_state, w_nextState;
  logic [1:0] r_ptr, w_nextPtr;
  logic [1:0] r_zone, w_nextZone;
  logic       r_mode, w_nextMode;
  logic [7:0] r_dwell, w_nextDwell;
  logic [7:0] r_guardCnt, w_nextGuardCnt;
  logic [3:0] r_grant, w_nextGrant;
  logic       r_heater, w_nextHeater;
  logic       r_cooler, w_nextCooler;

  logic       w_found;
  logic [1:0] w_pick;
  logic [1:0] w_idx;
  logic       w_release;
  logic       w_preempt;

`ifdef INCUBATOR_SCHED_PREEMPT_EN
  localparam logic [7:0] SliceLast = 8'(SLICE - 1);
  // Time-slice expiry: long enough on the stage and somebody else is waiting.
  always_comb begin
    w_preempt = (r_dwell >= SliceLast) && ((req & ~r_grant) != 4'b0000);
  end
`else
  logic [7:0] w_unusedSlice;
  assign w_unusedSlice = 8'(SLICE);
  // Without preemption a grant only ends through the normal release rule.
  always_comb begin
    w_preempt = 1'b0;
  end
`endif

  // Round-robin search starting at the pointer, plus the release decision for ON.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = r_ptr;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
    w_release = ((r_dwell >= MinOnLast) &&
                 (!req[r_zone] || (mode[r_zone] != r_mode))) || w_preempt;
  end

  // Next-state and next-output logic; outputs are computed here and registered.
  always_comb begin
    w_nextState    = r_state;
    w_nextPtr      = r_ptr;
    w_nextZone     = r_zone;
    w_nextMode     = r_mode;
    w_nextDwell    = r_dwell;
    w_nextGuardCnt = r_guardCnt;
    w_nextGrant    = r_grant;
    w_nextHeater   = r_heater;
    w_nextCooler   = r_cooler;
    case (r_state)
      S_IDLE: begin
        w_nextGrant  = 4'b0000;
        w_nextHeater = 1'b0;
        w_nextCooler = 1'b0;
        if (w_found) begin
          w_nextState  = S_ON;
          w_nextZone   = w_pick;
          w_nextMode   = mode[w_pick];
          w_nextDwell  = 8'd0;
          w_nextPtr    = w_pick + 2'd1;
          w_nextGrant  = 4'b0001 << w_pick;
          w_nextHeater = mode[w_pick];
          w_nextCooler = ~mode[w_pick];
        end
      end
      S_ON: begin
        w_nextDwell = (r_dwell == 8'hFF) ? r_dwell : r_dwell + 8'd1;
        if (w_release) begin
          w_nextState    = S_GUARD;
          w_nextGuardCnt = 8'd0;
          w_nextGrant    = 4'b0000;
          w_nextHeater   = 1'b0;
          w_nextCooler   = 1'b0;
        end
      end
      S_GUARD: begin
        w_nextGrant  = 4'b0000;
        w_nextHeater = 1'b0;
        w_nextCooler = 1'b0;
        if (r_guardCnt >= GuardLast) begin
          w_nextState = S_IDLE;
        end else begin
          w_nextGuardCnt = r_guardCnt + 8'd1;
        end
      end
      default: begin
        w_nextState  = S_IDLE;
        w_nextGrant  = 4'b0000;
        w_nextHeater = 1'b0;
        w_nextCooler = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops everything immediately, no dead time.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'd0;
      r_zone     <= 2'd0;
      r_mode     <= 1'b0;
      r_dwell    <= 8'd0;
      r_guardCnt <= 8'd0;
      r_grant    <= 4'b0000;
      r_heater   <= 1'b0;
      r_cooler   <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_ptr      <= w_nextPtr;
      r_zone     <= w_nextZone;
      r_mode     <= w_nextMode;
      r_dwell    <= w_nextDwell;
      r_guardCnt <= w_nextGuardCnt;
      r_grant    <= w_nextGrant;
      r_heater   <= w_nextHeater;
      r_cooler   <= w_nextCooler;
    end
  end

  assign grant  = r_grant;
  assign Heater = r_heater;
  assign Cooler = r_cooler;
  assign busy   = (r_state != S_IDLE);

endmodule
